pix_capture: RTL and testbench
==============================

PIX_CAPTURE -- requirements
Module: pix_capture

Interface
REQ-001 SHALL have parameter IMG_DIM, default 28, image width and height in pixels (coordinates 1..IMG_DIM).
REQ-002 SHALL have parameter PIX_W, default 8, pixel data width in bits.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port H_cont  input  5  column of current strobe, 1-based.
REQ-006 SHALL have port V_cont  input  5  row of current strobe, 1-based.
REQ-007 SHALL have port start_stream  input  1  single-cycle strobe; H_cont, V_cont, pix_data valid when high.
REQ-008 SHALL have port pix_data  input  PIX_W  pixel value accompanying start_stream.
REQ-009 SHALL have port rd_addr  input  10  buffer read address, row-major, 0..IMG_DIM*IMG_DIM-1.
REQ-010 SHALL have port rd_data  output  PIX_W  buffer contents at rd_addr, registered.
REQ-011 SHALL have port busy  output  1  high while a frame is being captured.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse on capture of last pixel.
REQ-013 SHALL have port seq_err  output  1  sticky sequence/range error flag.
REQ-014 SHALL have port pix_cnt  output  10  pixels written in current frame.

Function
REQ-015 SHALL implement states IDLE, CAPTURE; all transitions on clk rising edge only.
REQ-016 SHALL, in IDLE, ignore strobes unless H_cont==1 and V_cont==1; such a strobe writes address 0, sets pix_cnt=1, moves to CAPTURE.
REQ-017 SHALL maintain expected coordinate (exp_h, exp_v); after accepting (h,v), exp advances h+1, wrapping to 1 with v+1 when h==IMG_DIM.
REQ-018 SHALL, in CAPTURE, on strobe matching expected coordinate, write pix_data to address (V_cont-1)*IMG_DIM+(H_cont-1) and increment pix_cnt.
REQ-019 SHALL, on accepted strobe at (IMG_DIM,IMG_DIM), assert frame_done the following cycle for exactly one cycle and return to IDLE.
REQ-020 SHALL, in CAPTURE, on strobe with coordinate not equal to expected, or H_cont/V_cont of 0 or >IMG_DIM, set seq_err, discard pixel, return to IDLE, clear pix_cnt.
REQ-021 SHALL, when a mismatching strobe is exactly (1,1), treat it as error and restart: set seq_err and accept it as first pixel of a new frame (state CAPTURE, pix_cnt=1).
REQ-022 SHALL keep seq_err set until reset; frame_done is unaffected by prior errors.
REQ-023 SHALL hold state and buffer unchanged on cycles with start_stream low, regardless of strobe spacing (no minimum/maximum gap).
REQ-024 SHALL assert busy exactly when state is CAPTURE.
REQ-025 SHALL provide rd_data one cycle after rd_addr; read during same-cycle write to same address returns the old value.
REQ-026 SHALL return undefined-but-stable rd_data for rd_addr >= IMG_DIM*IMG_DIM; no write occurs there.
REQ-027 SHALL compute addresses in 10 bits without overflow for IMG_DIM<=32.
REQ-028 SHALL leave pix_cnt at IMG_DIM*IMG_DIM after frame_done until next accepted (1,1) strobe.

Reset
REQ-029 SHALL, on reset high at a clock edge, set state IDLE, busy=0, frame_done=0, seq_err=0, pix_cnt=0, exp=(1,1).
REQ-030 SHALL not clear buffer contents on reset; rd_data remains a registered read.
REQ-031 SHALL give reset priority over a coincident start_stream; that strobe is discarded.
REQ-032 SHALL, on reset mid-frame, abandon capture with no frame_done pulse.

Verification
REQ-033 SHALL pass: 784 strobes in raster order, every 16 cycles, pix_data=(addr mod 256) -> frame_done one pulse after (28,28) strobe; reading addr 0..783 returns addr mod 256; seq_err=0.
REQ-034 SHALL pass: idle strobes at (5,3) then (1,1) -> first two ignored/accepted respectively, pix_cnt=1, busy=1.
REQ-035 SHALL pass: after 30 good pixels, strobe (4,2) instead of (3,2) -> seq_err=1, busy=0, pix_cnt=0, no frame_done.
REQ-036 SHALL pass: after 100 good pixels, strobe (1,1) -> seq_err=1, busy=1, pix_cnt=1, addr 0 overwritten.
REQ-037 SHALL pass: reset asserted coincident with 500th strobe -> busy=0, pix_cnt=0, no frame_done; next full frame completes normally.
REQ-038 SHALL pass: back-to-back strobes every cycle for a full frame -> frame_done once, all 784 values correct.

Source files
------------

// File: rtl/pix_capture.sv
`timescale 1ns/1ps
// pix_capture: raster-order pixel capture into an IMG_DIM x IMG_DIM frame buffer
// with sequence checking, restart on (1,1) and a registered read port.
module pix_capture #(
  parameter int unsigned IMG_DIM = 28,
  parameter int unsigned PIX_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       H_cont,
  input  logic [4:0]       V_cont,
  input  logic             start_stream,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [9:0]       rd_addr,
  output logic [PIX_W-1:0] rd_data,
  output logic             busy,
  output logic             frame_done,
  output logic             seq_err,
  output logic [9:0]       pix_cnt
);

  localparam int unsigned DEPTH = IMG_DIM * IMG_DIM;
  localparam int unsigned AW    = 10;
  localparam int unsigned EW    = 6;
  localparam logic [EW-1:0] DIM_E = EW'(IMG_DIM);
  localparam logic [EW-1:0] ONE_E = EW'(1);

  typedef enum logic {IDLE, CAPTURE} state_e;

  state_e            state_q, state_d;
  logic [EW-1:0]     exp_h_q, exp_h_d;
  logic [EW-1:0]     exp_v_q, exp_v_d;
  logic [AW-1:0]     pix_cnt_q, pix_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              seq_err_q, seq_err_d;
  logic              busy_q, busy_d;
  logic [PIX_W-1:0]  rd_data_q, rd_data_d;
  logic              accept_c;
  logic              wr_en_c;
  logic [AW-1:0]     wr_addr_c;
  logic [PIX_W-1:0]  mem [DEPTH];

  // Coordinates widened by one bit so IMG_DIM=32 compares correctly.
  logic [EW-1:0] h_e_c, v_e_c;
  logic          first_c, last_c, match_c;
  assign h_e_c   = EW'(H_cont);
  assign v_e_c   = EW'(V_cont);
  assign first_c = (h_e_c == ONE_E) && (v_e_c == ONE_E);
  assign last_c  = (h_e_c == DIM_E) && (v_e_c == DIM_E);
  assign match_c = (h_e_c == exp_h_q) && (v_e_c == exp_v_q);

  // Row-major write address; only used for accepted (in-range) coordinates.
  assign wr_addr_c = AW'(v_e_c - ONE_E) * AW'(IMG_DIM) + AW'(h_e_c - ONE_E);

  // Next-state, sequence checking and write control.
  always_comb begin
    state_d      = state_q;
    exp_h_d      = exp_h_q;
    exp_v_d      = exp_v_q;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    seq_err_d    = seq_err_q;
    accept_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_stream && first_c) accept_c = 1'b1;
      end
      CAPTURE: begin
        if (start_stream) begin
          if (match_c) begin
            accept_c = 1'b1;
          end else begin
            // Any out-of-sequence or out-of-range strobe is an error; (1,1) restarts.
            seq_err_d = 1'b1;
            if (first_c) begin
              accept_c = 1'b1;
            end else begin
              state_d   = IDLE;
              pix_cnt_d = '0;
              exp_h_d   = ONE_E;
              exp_v_d   = ONE_E;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      state_d   = CAPTURE;
      pix_cnt_d = first_c ? AW'(1) : pix_cnt_q + AW'(1);
      if (last_c) begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
        exp_h_d      = ONE_E;
        exp_v_d      = ONE_E;
      end else if (h_e_c == DIM_E) begin
        exp_h_d = ONE_E;
        exp_v_d = v_e_c + ONE_E;
      end else begin
        exp_h_d = h_e_c + ONE_E;
        exp_v_d = v_e_c;
      end
    end

    busy_d  = (state_d == CAPTURE);
    wr_en_c = accept_c && !reset;
    rd_data_d = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : rd_data_q;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      exp_h_q      <= ONE_E;
      exp_v_q      <= ONE_E;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_h_q      <= exp_h_d;
      exp_v_q      <= exp_v_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
      seq_err_q    <= seq_err_d;
      busy_q       <= busy_d;
    end
  end

  // Frame buffer and registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_addr_c] <= pix_data;
    rd_data_q <= rd_data_d;
  end

  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign seq_err    = seq_err_q;
  assign pix_cnt    = pix_cnt_q;

endmodule

// File: tb/tb_pix_capture.sv
`timescale 1ns/1ps
// Self-checking bench for pix_capture with a reference frame buffer and read scoreboard.
module tb_pix_capture;

  localparam int DIM  = 28;
  localparam int NPIX = DIM * DIM;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] H_cont = '0;
  logic [4:0] V_cont = '0;
  logic       start_stream = 1'b0;
  logic [7:0] pix_data = '0;
  logic [9:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       busy;
  logic       frame_done;
  logic       seq_err;
  logic [9:0] pix_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;
  int fd_base;
  logic [7:0] ref_mem [NPIX];
  logic [7:0] exp_q [$];

  pix_capture #(.IMG_DIM(DIM), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .H_cont(H_cont), .V_cont(V_cont),
    .start_stream(start_stream), .pix_data(pix_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .frame_done(frame_done),
    .seq_err(seq_err), .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  // Count frame_done pulses away from the active edge.
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One strobe cycle; outputs reflect it on return.
  task automatic strobe(input int h, input int v, input int d);
    H_cont = 5'(h);
    V_cont = 5'(v);
    pix_data = 8'(d);
    start_stream = 1'b1;
    tick();
    start_stream = 1'b0;
  endtask

  // Raster pixels first..first+n-1, data (index+base) mod 256, every gap cycles.
  task automatic send_pixels(input int first, input int n, input int base, input int gap);
    for (int i = first; i < first + n; i++) begin
      strobe(i % DIM + 1, i / DIM + 1, (i + base) % 256);
      ref_mem[i] = 8'((i + base) % 256);
      if (i == NPIX - 1) begin
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        tick();
        check("frame_done_single", 32'(frame_done), 32'd0);
        if (gap > 2) idle(gap - 2);
      end else if (gap > 1) begin
        idle(gap - 1);
      end
    end
  endtask

  // Scoreboard read: expectation queued with the address, compared when data returns.
  task automatic read_check(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      rd_addr = 10'(a);
      exp_q.push_back(ref_mem[a]);
      tick();
      check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) ref_mem[i] = '0;

    // Reset state
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_pix_cnt", 32'(pix_cnt), 32'd0);

    // Full frame, one strobe every 16 cycles
    fd_base = fd_cnt;
    send_pixels(0, NPIX, 0, 16);
    check("f1_fd_count", 32'(fd_cnt - fd_base), 32'd1);
    check("f1_seq_err", 32'(seq_err), 32'd0);
    check("f1_busy", 32'(busy), 32'd0);
    check("f1_pix_cnt", 32'(pix_cnt), 32'(NPIX));
    read_check(0, NPIX - 1);

    // Idle strobes: (5,3) ignored, (1,1) starts a frame
    strobe(5, 3, 8'hAA);
    idle(1);
    check("idle_ign_busy", 32'(busy), 32'd0);
    check("idle_ign_cnt", 32'(pix_cnt), 32'(NPIX));
    check("idle_ign_err", 32'(seq_err), 32'd0);
    strobe(1, 1, 8'h11);
    ref_mem[0] = 8'h11;
    check("idle_acc_busy", 32'(busy), 32'd1);
    check("idle_acc_cnt", 32'(pix_cnt), 32'd1);

    // 30 good pixels, then (4,2) instead of (3,2)
    fd_base = fd_cnt;
    send_pixels(1, 29, 8'h40, 2);
    check("p30_cnt", 32'(pix_cnt), 32'd30);
    strobe(4, 2, 8'h77);
    check("seq_err_set", 32'(seq_err), 32'd1);
    check("seq_busy", 32'(busy), 32'd0);
    check("seq_cnt", 32'(pix_cnt), 32'd0);
    idle(2);
    check("seq_no_fd", 32'(fd_cnt - fd_base), 32'd0);
    read_check(0, 40);

    // 100 good pixels back-to-back, then (1,1) restarts
    do_reset();
    check("rst2_seq_err", 32'(seq_err), 32'd0);
    send_pixels(0, 100, 8'h80, 1);
    check("p100_cnt", 32'(pix_cnt), 32'd100);
    strobe(1, 1, 8'hEE);
    ref_mem[0] = 8'hEE;
    check("restart_seq_err", 32'(seq_err), 32'd1);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_cnt", 32'(pix_cnt), 32'd1);
    read_check(0, 5);

    // Out-of-range coordinate while capturing
    do_reset();
    send_pixels(0, 5, 0, 1);
    strobe(0, 1, 8'h22);
    check("range_seq_err", 32'(seq_err), 32'd1);
    check("range_busy", 32'(busy), 32'd0);
    check("range_cnt", 32'(pix_cnt), 32'd0);

    // Reset coincident with the 500th strobe
    do_reset();
    fd_base = fd_cnt;
    send_pixels(0, 499, 8'h33, 2);
    reset = 1'b1;
    strobe(499 % DIM + 1, 499 / DIM + 1, 8'h5A);
    reset = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_cnt", 32'(pix_cnt), 32'd0);
    check("rstmid_fd", 32'(frame_done), 32'd0);
    idle(3);
    check("rstmid_no_fd", 32'(fd_cnt - fd_base), 32'd0);
    read_check(495, 500);
    fd_base = fd_cnt;
    send_pixels(0, NPIX, 8'h55, 3);
    check("f2_fd_count", 32'(fd_cnt - fd_base), 32'd1);
    check("f2_seq_err", 32'(seq_err), 32'd0);
    read_check(0, NPIX - 1);

    // Back-to-back full frame
    fd_base = fd_cnt;
    send_pixels(0, NPIX, 8'h99, 1);
    idle(2);
    check("f3_fd_count", 32'(fd_cnt - fd_base), 32'd1);
    check("f3_pix_cnt", 32'(pix_cnt), 32'(NPIX));
    read_check(0, NPIX - 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
